// File: rtl/smpl_clk_pkg.sv
// Shared types and constants for the logic-analyzer sample-rate generator.
package smpl_clk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [1:0] SEL_C0 = 2'b00;
    localparam logic [1:0] SEL_C1 = 2'b01;
    localparam logic [1:0] SEL_C2 = 2'b10;
    localparam logic [1:0] SEL_C3 = 2'b11;

    localparam int unsigned DEF_DIV0 = 1;
    localparam int unsigned DEF_DIV1 = 10;
    localparam int unsigned DEF_DIV2 = 100;
    localparam int unsigned DEF_DIV3 = 1000;

endpackage

// File: rtl/smpl_clk_gen.sv
// Sample-rate generator: one-cycle sample strobe, boundary-aligned rate changes.
// Optional square-wave sample clock enabled by defining SMPL_CLK_OUT_EN.
module smpl_clk_gen
    import smpl_clk_pkg::*;
#(
    parameter int unsigned DIV0  = DEF_DIV0,
    parameter int unsigned DIV1  = DEF_DIV1,
    parameter int unsigned DIV2  = DEF_DIV2,
    parameter int unsigned DIV3  = DEF_DIV3,
    parameter int unsigned CNT_W = 10
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic [1:0] smpl_clk_sel,
    input  logic       i_run,
    output logic       o_smpl_en,
    output logic       o_smpl_clk,
    output logic [1:0] o_sel_active,
    output logic       o_pending
);

    // Terminal counts are precomputed so the compare stays CNT_W bits wide.
    localparam logic [CNT_W-1:0] M0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] M1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] M2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] M3 = CNT_W'(DIV3 - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_m1;
    logic [1:0]       sel_q;
    logic [1:0]       act_q, act_d;
    logic             pend_q, pend_d;
    logic             en_q, en_d;
    logic             wrap;

    always_comb begin
        div_m1 = M0;
        case (act_q)
            SEL_C0: div_m1 = M0;
            SEL_C1: div_m1 = M1;
            SEL_C2: div_m1 = M2;
            SEL_C3: div_m1 = M3;
            default: div_m1 = M0;
        endcase
    end

    assign wrap = (cnt_q == div_m1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        pend_d  = pend_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                act_d  = sel_q;
                pend_d = 1'b0;
                if (i_run) state_d = RUN;
            end
            RUN, PEND: begin
                if (!i_run) begin
                    // Stopping adopts any requested rate immediately.
                    state_d = IDLE;
                    cnt_d   = '0;
                    act_d   = sel_q;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + 1'b1;
                    en_d  = wrap;
                    if (state_q == RUN) begin
                        if (sel_q != act_q) begin
                            state_d = PEND;
                            pend_d  = 1'b1;
                        end
                    end else if (wrap) begin
                        act_d   = sel_q;
                        pend_d  = 1'b0;
                        state_d = RUN;
                    end else if (sel_q == act_q) begin
                        pend_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q  <= '0;
            sel_q  <= SEL_C0;
            act_q  <= SEL_C0;
            pend_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= smpl_clk_sel;
            act_q  <= act_d;
            pend_q <= pend_d;
            en_q   <= en_d;
        end
    end

`ifdef SMPL_CLK_OUT_EN
    localparam logic [CNT_W:0] H0 = (CNT_W+1)'((DIV0 + 1) / 2);
    localparam logic [CNT_W:0] H1 = (CNT_W+1)'((DIV1 + 1) / 2);
    localparam logic [CNT_W:0] H2 = (CNT_W+1)'((DIV2 + 1) / 2);
    localparam logic [CNT_W:0] H3 = (CNT_W+1)'((DIV3 + 1) / 2);

    logic [CNT_W:0] half;
    logic           sclk_q;

    always_comb begin
        half = H0;
        case (act_q)
            SEL_C0: half = H0;
            SEL_C1: half = H1;
            SEL_C2: half = H2;
            SEL_C3: half = H3;
            default: half = H0;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= (state_q != IDLE) && i_run && ({1'b0, cnt_d} < half);
        end
    end

    assign o_smpl_clk = sclk_q;
`else
    assign o_smpl_clk = 1'b0;
`endif

    assign o_smpl_en    = en_q;
    assign o_sel_active = act_q;
    assign o_pending    = pend_q;

endmodule
